qed_consistency_checker: RTL and testbench

- Receive side of the QED instruction transformation: observes retired original and duplicate instructions and, at matched points, reads both register-file halves back through the inverse mapping. Original reg i (1..15) pairs with duplicate reg {1'b1, i[3:0]}; x0 and x16 are excluded.
- Sits beside the core's commit stage and register-file debug read port.
- Stalls the core during a scan and reports pass/fail to the formal/sim harness.

---
 rtl/qed_pkg.sv | 30 +++
 rtl/qed_commit_counter.sv | 50 +++++
 rtl/qed_consistency_checker.sv | 139 +++++++++++++
 tb/tb_qed_consistency_checker.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
// Shared definitions for the QED consistency checker: scan state encoding,
// register/memory partition constants and the original->duplicate map.
// Optional memory scan is enabled by defining QED_MEM_CHECK_EN.
package qed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ORIG,
        RD_DUP,
        CMP,
        MRD_ORIG,
        MRD_DUP,
        MCMP,
        DONE
    } qed_state_e;

    // Address bit that selects the duplicate half of the register file / memory.
    localparam int DUP_BIT   = 4;
    localparam int NUM_PAIRS = 15;
    localparam int MEM_WORDS = 16;

    // Inverse mapping: original index -> duplicate address in the upper half.
    function automatic logic [4:0] dup_of(input logic [3:0] idx);
        logic [4:0] addr;
        addr          = {1'b0, idx};
        addr[DUP_BIT] = 1'b1;
        return addr;
    endfunction

endpackage

// File: rtl/qed_commit_counter.sv
// Counts retired original and duplicate instructions with saturating
// counters, tracks whether anything new retired since the last scan, and
// raises the scan trigger when both streams line up.
module qed_commit_counter #(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic commit_valid,
    input  logic commit_dup,
    input  logic qed_enable,
    input  logic clear_dirty,
    output logic dirty,
    output logic trigger
);

    logic [CNT_W-1:0] orig_cnt;
    logic [CNT_W-1:0] dup_cnt;
    logic             count_orig;
    logic             count_dup;

    // Counters stop at all-ones so two saturated streams still compare equal.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    assign count_orig = commit_valid & ~commit_dup & qed_enable;
    assign count_dup  = commit_valid &  commit_dup & qed_enable;

    // Count commits; a new commit re-arms dirty even in the cycle a scan clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            orig_cnt <= '0;
            dup_cnt  <= '0;
            dirty    <= 1'b0;
        end else begin
            if (count_orig) orig_cnt <= sat_inc(orig_cnt);
            if (count_dup)  dup_cnt  <= sat_inc(dup_cnt);
            if (count_orig || count_dup) begin
                dirty <= 1'b1;
            end else if (clear_dirty) begin
                dirty <= 1'b0;
            end
        end
    end

    // Only start on a quiet cycle so the register file is not changing under the scan.
    assign trigger = qed_enable & dirty & (orig_cnt == dup_cnt) & ~commit_valid;

endmodule

// File: rtl/qed_consistency_checker.sv
// QED receive-side checker: at matched commit points, stalls the core and
// reads every original/duplicate register pair through the debug port,
// flagging the first pair that differs. Defining QED_MEM_CHECK_EN appends a
// scan of the two 16-word data-memory halves after the register pairs.
module qed_consistency_checker #(
    parameter int CNT_W     = 16,
    parameter int NUM_PAIRS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic        commit_dup,
    input  logic        qed_enable,
`ifdef QED_MEM_CHECK_EN
    output logic [4:0]  dmem_raddr,
    input  logic [31:0] dmem_rdata,
`endif
    output logic        core_stall,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        qed_check_done,
    output logic        qed_mismatch,
    output logic [3:0]  qed_mismatch_idx,
    output logic        qed_protocol_err
);

    import qed_pkg::*;

    qed_state_e  state;
    logic [3:0]  p;
    logic [31:0] orig_q;
    logic        dirty;
    logic        trigger;

    qed_commit_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_dup   (commit_dup),
        .qed_enable   (qed_enable),
        .clear_dirty  (state == DONE),
        .dirty        (dirty),
        .trigger      (trigger)
    );

    assign core_stall     = (state != IDLE);
    assign qed_check_done = (state == DONE);

    // Read address follows the state so data returns in the following state.
    always_comb begin
        rf_raddr = '0;
        case (state)
            RD_ORIG: rf_raddr = {1'b0, p};
            RD_DUP:  rf_raddr = dup_of(p);
            default: rf_raddr = '0;
        endcase
    end

`ifdef QED_MEM_CHECK_EN
    // Memory read address, same original/duplicate split as the registers.
    always_comb begin
        dmem_raddr = '0;
        case (state)
            MRD_ORIG: dmem_raddr = {1'b0, p};
            MRD_DUP:  dmem_raddr = dup_of(p);
            default:  dmem_raddr = '0;
        endcase
    end
`endif

    // Hold the original-half word while the duplicate half is being read.
    always_ff @(posedge clk) begin
        if (state == RD_DUP) orig_q <= rf_rdata;
`ifdef QED_MEM_CHECK_EN
        else if (state == MRD_DUP) orig_q <= dmem_rdata;
`endif
    end

    // Scan sequencer with sticky error reporting; scans never abort early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            p                <= '0;
            qed_mismatch     <= 1'b0;
            qed_mismatch_idx <= '0;
            qed_protocol_err <= 1'b0;
        end else begin
            if (commit_valid && state != IDLE) qed_protocol_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= RD_ORIG;
                        p     <= 4'd1;
                    end
                end
                RD_ORIG: state <= RD_DUP;
                RD_DUP:  state <= CMP;
                CMP: begin
                    if (rf_rdata != orig_q && !qed_mismatch) begin
                        qed_mismatch     <= 1'b1;
                        qed_mismatch_idx <= p;
                    end
                    if (p == 4'(NUM_PAIRS)) begin
`ifdef QED_MEM_CHECK_EN
                        state <= MRD_ORIG;
                        p     <= '0;
`else
                        state <= DONE;
`endif
                    end else begin
                        p     <= p + 4'd1;
                        state <= RD_ORIG;
                    end
                end
`ifdef QED_MEM_CHECK_EN
                MRD_ORIG: state <= MRD_DUP;
                MRD_DUP:  state <= MCMP;
                MCMP: begin
                    if (dmem_rdata != orig_q && !qed_mismatch) begin
                        qed_mismatch     <= 1'b1;
                        qed_mismatch_idx <= 4'hF;
                    end
                    if (p == 4'(MEM_WORDS - 1)) begin
                        state <= DONE;
                    end else begin
                        p     <= p + 4'd1;
                        state <= MRD_ORIG;
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Directed bench for qed_consistency_checker with a cycle-level reference
// model of the commit/scan behaviour and literal checks of key results.
`timescale 1ns/1ps
module tb_qed_consistency_checker;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef QED_MEM_CHECK_EN
    localparam int SCAN_LEN = 93;
`else
    localparam int SCAN_LEN = 45;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic        commit_dup = 1'b0;
    logic        qed_enable = 1'b1;
    logic        core_stall;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata = '0;
    logic        qed_check_done;
    logic        qed_mismatch;
    logic [3:0]  qed_mismatch_idx;
    logic        qed_protocol_err;
    logic [31:0] rf [32];
`ifdef QED_MEM_CHECK_EN
    logic [4:0]  dmem_raddr;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] dmem [32];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    qed_consistency_checker #(
        .CNT_W     (TB_CNT_W),
        .NUM_PAIRS (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_dup       (commit_dup),
        .qed_enable       (qed_enable),
`ifdef QED_MEM_CHECK_EN
        .dmem_raddr       (dmem_raddr),
        .dmem_rdata       (dmem_rdata),
`endif
        .core_stall       (core_stall),
        .rf_raddr         (rf_raddr),
        .rf_rdata         (rf_rdata),
        .qed_check_done   (qed_check_done),
        .qed_mismatch     (qed_mismatch),
        .qed_mismatch_idx (qed_mismatch_idx),
        .qed_protocol_err (qed_protocol_err)
    );

    // Register file / memory with one-cycle read latency.
    always @(posedge clk) rf_rdata <= rf[rf_raddr];
`ifdef QED_MEM_CHECK_EN
    always @(posedge clk) dmem_rdata <= dmem[dmem_raddr];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_orig, m_dup, m_left, m_idx;
    bit m_dirty, m_perr, m_mm;

    function automatic int first_bad();
        for (int i = 1; i <= 15; i++)
            if (rf[i] != rf[16 + i]) return i;
`ifdef QED_MEM_CHECK_EN
        for (int w = 0; w < 16; w++)
            if (dmem[w] != dmem[16 + w]) return 15;
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        int fb;
        if (rst) begin
            m_orig = 0; m_dup = 0; m_left = 0; m_idx = 0;
            m_dirty = 0; m_perr = 0; m_mm = 0;
        end else begin
            if (m_left > 0) begin
                if (commit_valid) m_perr = 1;
                if (m_left == 1) m_dirty = 0;
                m_left--;
            end else if (qed_enable && m_dirty && m_orig == m_dup && !commit_valid) begin
                m_left = SCAN_LEN + 1;
                fb = first_bad();
                if (!m_mm && fb != 0) begin
                    m_mm  = 1;
                    m_idx = fb;
                end
            end
            if (commit_valid && qed_enable) begin
                if (commit_dup) m_dup = (m_dup < CNT_MAX) ? m_dup + 1 : m_dup;
                else            m_orig = (m_orig < CNT_MAX) ? m_orig + 1 : m_orig;
                m_dirty = 1;
            end
        end
    end

    // Compare DUT against the model every cycle, mismatch flags once a scan has finished.
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall", core_stall, m_left > 0);
            check("done", qed_check_done, m_left == 1);
            check("protocol_err", qed_protocol_err, m_perr);
            check("orig_cnt", dut.u_cnt.orig_cnt, m_orig);
            check("dup_cnt", dut.u_cnt.dup_cnt, m_dup);
            if (m_left <= 1) begin
                check("mismatch", qed_mismatch, m_mm);
                check("mismatch_idx", qed_mismatch_idx, m_idx);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic init_arrays();
        for (int i = 0; i < 16; i++) begin
            rf[i]      = 32'h1000_0000 + i * 32'h0101;
            rf[16 + i] = rf[i];
        end
        rf[0]  = 32'h0;
        rf[16] = 32'hDEAD_BEEF;
`ifdef QED_MEM_CHECK_EN
        for (int w = 0; w < 16; w++) begin
            dmem[w]      = 32'h00A0_0000 + w;
            dmem[16 + w] = dmem[w];
        end
`endif
    endtask

    task automatic commits(input int n, input bit dup);
        for (int i = 0; i < n; i++) begin
            commit_valid = 1'b1;
            commit_dup   = dup;
            tick();
        end
        commit_valid = 1'b0;
        commit_dup   = 1'b0;
    endtask

    // Wait for a scan and measure it; optionally inject a commit or drop enable mid-scan.
    task automatic wait_scan(input int inject, input int drop_en,
                             output int stall_cycles, output int done_pos);
        int guard;
        guard = 0;
        stall_cycles = 0;
        done_pos = -1;
        while (!core_stall && guard < 200) begin
            tick();
            guard++;
        end
        while (core_stall && guard < 400) begin
            stall_cycles++;
            if (qed_check_done) done_pos = stall_cycles;
            if (stall_cycles == inject) begin
                commit_valid = 1'b1;
                commit_dup   = 1'b1;
            end
            if (stall_cycles == drop_en) qed_enable = 1'b0;
            tick();
            guard++;
            commit_valid = 1'b0;
            commit_dup   = 1'b0;
        end
    endtask

    task automatic check_scan(input string tag, input int stall_cycles, input int done_pos);
        check({tag, "_scan_cycles"}, done_pos - 1, SCAN_LEN);
        check({tag, "_stall_len"}, stall_cycles, SCAN_LEN + 1);
    endtask

    initial begin
        int sc, dp;
        init_arrays();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check("rst_stall", core_stall, 0);
        check("rst_raddr", rf_raddr, 0);
        check("rst_done", qed_check_done, 0);
        check("rst_mismatch", qed_mismatch, 0);
        check("rst_idx", qed_mismatch_idx, 0);
        check("rst_perr", qed_protocol_err, 0);

        // All pairs equal
        commits(3, 1'b0);
        commits(3, 1'b1);
        check("t1_no_stall_trigger_cycle", core_stall, 0);
        tick();
        check("t1_stall_starts", core_stall, 1);
        check("t1_first_raddr", rf_raddr, 5'd1);
        wait_scan(0, 0, sc, dp);
        check_scan("t1", sc, dp);
        check("t1_mismatch", qed_mismatch, 0);

        // Single mismatch at pair 5
        rf[5]  = 32'h1234;
        rf[21] = 32'h1235;
        commits(3, 1'b0);
        commits(3, 1'b1);
        wait_scan(0, 0, sc, dp);
        check_scan("t2", sc, dp);
        check("t2_mismatch", qed_mismatch, 1);
        check("t2_idx", qed_mismatch_idx, 4'd5);
        init_arrays();
        do_reset();

        // Mismatches at pairs 3 and 9: first one kept
        rf[19] = 32'hFFFF_0003;
        rf[9]  = 32'h0000_0009;
        commits(3, 1'b0);
        commits(3, 1'b1);
        wait_scan(0, 0, sc, dp);
        check_scan("t3", sc, dp);
        check("t3_idx", qed_mismatch_idx, 4'd3);
        repeat (5) tick();
        check("t3_idx_held", qed_mismatch_idx, 4'd3);
        init_arrays();
        do_reset();

        // Commit during the 10th stall cycle
        commits(3, 1'b0);
        commits(3, 1'b1);
        wait_scan(10, 0, sc, dp);
        check_scan("t4", sc, dp);
        check("t4_perr", qed_protocol_err, 1);
        check("t4_dup_cnt", dut.u_cnt.dup_cnt, 4);
        check("t4_mismatch", qed_mismatch, 0);
        repeat (8) tick();
        check("t4_no_rescan", core_stall, 0);
        do_reset();

        // Reset during CMP of pair 7 (stall cycle 21), after pair 3 already failed
        rf[3] = 32'h0BAD_0003;
        commits(3, 1'b0);
        commits(3, 1'b1);
        tick();
        repeat (20) tick();
        check("t5_mismatch_before_rst", qed_mismatch, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_stall", core_stall, 0);
        check("t5_mismatch", qed_mismatch, 0);
        check("t5_idx", qed_mismatch_idx, 0);
        check("t5_perr", qed_protocol_err, 0);
        check("t5_done", qed_check_done, 0);
        check("t5_orig_cnt", dut.u_cnt.orig_cnt, 0);
        check("t5_dup_cnt", dut.u_cnt.dup_cnt, 0);
        init_arrays();
        repeat (3) tick();
        check("t5_stays_idle", core_stall, 0);

        // Disabled: commits not counted; enable dropping mid-scan lets the scan finish
        qed_enable = 1'b0;
        commits(2, 1'b0);
        repeat (3) tick();
        check("t6_cnt_hold", dut.u_cnt.orig_cnt, 0);
        qed_enable = 1'b1;
        commits(1, 1'b0);
        commits(1, 1'b1);
        wait_scan(0, 5, sc, dp);
        check_scan("t6", sc, dp);
        commits(1, 1'b0);
        repeat (5) tick();
        check("t6_disabled_cnt", dut.u_cnt.orig_cnt, 1);
        qed_enable = 1'b1;
        do_reset();

        // Saturation: both counters stop at all-ones and still trigger scans
        commits(17, 1'b0);
        check("t7_orig_sat", dut.u_cnt.orig_cnt, CNT_MAX);
        commits(17, 1'b1);
        check("t7_dup_sat", dut.u_cnt.dup_cnt, CNT_MAX);
        wait_scan(0, 0, sc, dp);
        check_scan("t7a", sc, dp);
        commits(1, 1'b0);
        wait_scan(0, 0, sc, dp);
        check_scan("t7b", sc, dp);
        check("t7_orig_still_sat", dut.u_cnt.orig_cnt, CNT_MAX);

`ifdef QED_MEM_CHECK_EN
        // Memory word 2 differs from word 18, registers equal
        do_reset();
        dmem[18] = 32'h5555_AAAA;
        commits(3, 1'b0);
        commits(3, 1'b1);
        wait_scan(0, 0, sc, dp);
        check_scan("t8", sc, dp);
        check("t8_mismatch", qed_mismatch, 1);
        check("t8_idx", qed_mismatch_idx, 4'hF);
        init_arrays();
`endif

        repeat (3) tick();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
